clk_wiz_sequencer: RTL and testbench

- Bring-up and supervision controller for the clock wizard that produces clk_6144mhz.
- Pulses the wizard reset and waits for locked, with a timeout and bounded retries.
- Requires locked to be stable before releasing the downstream audio-domain reset.
- Re-sequences on lock loss; latches a fault after exhausted retries. Runs on the wizard input clock.

---
 rtl/clk_seq_pkg.sv | 21 ++
 rtl/sync_2ff.sv | 22 ++
 rtl/clk_wiz_sequencer.sv | 146 ++++++++++++++
 tb/tb_clk_wiz_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_seq_pkg.sv
// Shared types and helpers for the clock wizard bring-up sequencer.
package clk_seq_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    RESET_PULSE = 3'd1,
    WAIT_LOCK   = 3'd2,
    STABILIZE   = 3'd3,
    RUNNING     = 3'd4,
    FAULT       = 3'd5
  } state_t;

  localparam int STATE_W    = 3;
  localparam int LOSS_CNT_W = 8;

  // Width needed to hold values 0..value-1, never less than one bit.
  function automatic int clog2_min1(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser for asynchronous level inputs.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops give the first stage a full cycle to settle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/clk_wiz_sequencer.sv
// Bring-up and supervision controller for the clock wizard generating
// clk_6144mhz: pulses the wizard reset, waits for a stable lock with a
// bounded number of retries, and gates the downstream audio-domain reset.
module clk_wiz_sequencer
  import clk_seq_pkg::*;
#(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES         = 3
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   enable,
  input  logic                                   restart,
  input  logic                                   clear_fault,
  input  logic                                   locked,
  output logic                                   mmcm_rst,
  output logic                                   domain_rst_n,
  output logic                                   ready,
  output logic                                   fault,
  output logic [clog2_min1(MAX_RETRIES + 1)-1:0] retry_count,
  output logic [LOSS_CNT_W-1:0]                  lock_loss_count,
  output logic [STATE_W-1:0]                     state_o
);

  localparam int RC_W      = clog2_min1(MAX_RETRIES + 1);
  localparam int MAX_A     = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ? RST_PULSE_CYCLES
                                                                      : LOCK_TIMEOUT_CYCLES;
  localparam int MAX_PARAM = (MAX_A > LOCK_STABLE_CYCLES) ? MAX_A : LOCK_STABLE_CYCLES;
  localparam int CNT_W     = clog2_min1(MAX_PARAM);

  localparam logic [CNT_W-1:0]      RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0]      TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]      STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RC_W-1:0]       RETRY_LIMIT  = RC_W'(MAX_RETRIES);
  localparam logic [LOSS_CNT_W-1:0] LOSS_MAX     = '1;

  state_t                  state;
  state_t                  state_n;
  logic [CNT_W-1:0]        cnt;
  logic                    cnt_inc;
  logic                    force_clr;
  logic                    cnt_clr;
  logic [RC_W-1:0]         retry_n;
  logic [LOSS_CNT_W-1:0]   loss_n;
  logic                    locked_s;

  sync_2ff u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (locked),
    .q     (locked_s)
  );

  // Next-state decision in priority order: enable, clear_fault, restart,
  // lock events, then counter expiry.
  always_comb begin
    state_n   = state;
    retry_n   = retry_count;
    loss_n    = lock_loss_count;
    cnt_inc   = 1'b0;
    force_clr = 1'b0;
    if (!enable) begin
      state_n = IDLE;
      retry_n = '0;
    end else if (state == FAULT) begin
      if (clear_fault) begin
        state_n = RESET_PULSE;
        retry_n = '0;
      end
    end else if (restart && (state != IDLE)) begin
      state_n   = RESET_PULSE;
      retry_n   = '0;
      force_clr = 1'b1;
    end else begin
      case (state)
        IDLE: state_n = RESET_PULSE;
        RESET_PULSE: begin
          if (cnt == RST_LAST) state_n = WAIT_LOCK;
          else                 cnt_inc = 1'b1;
        end
        WAIT_LOCK: begin
          if (locked_s) begin
            state_n = STABILIZE;
          end else if (cnt == TIMEOUT_LAST) begin
            if (retry_count == RETRY_LIMIT) begin
              state_n = FAULT;
            end else begin
              state_n = RESET_PULSE;
              retry_n = retry_count + 1'b1;
            end
          end else begin
            cnt_inc = 1'b1;
          end
        end
        STABILIZE: begin
          if (!locked_s)                state_n = WAIT_LOCK;
          else if (cnt == STABLE_LAST)  state_n = RUNNING;
          else                          cnt_inc = 1'b1;
        end
        RUNNING: begin
          if (!locked_s) begin
            state_n = RESET_PULSE;
            retry_n = '0;
            if (lock_loss_count != LOSS_MAX) loss_n = lock_loss_count + 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // A restart inside RESET_PULSE keeps the state, so it must still restart the pulse.
  always_comb begin
    cnt_clr = force_clr || (state_n != state);
  end

  // State, counter, statistics and outputs all update together, with the
  // outputs decoded from the next state so they move on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      cnt             <= '0;
      retry_count     <= '0;
      lock_loss_count <= '0;
      mmcm_rst        <= 1'b1;
      domain_rst_n    <= 1'b0;
      ready           <= 1'b0;
      fault           <= 1'b0;
    end else begin
      state           <= state_n;
      retry_count     <= retry_n;
      lock_loss_count <= loss_n;
      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + 1'b1;
      mmcm_rst        <= (state_n == IDLE) || (state_n == RESET_PULSE) || (state_n == FAULT);
      domain_rst_n    <= (state_n == RUNNING);
      ready           <= (state_n == RUNNING);
      fault           <= (state_n == FAULT);
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_clk_wiz_sequencer.sv
// Scoreboard bench for clk_wiz_sequencer: stimulus queues timed expectations,
// a monitor compares them on the falling clock edge.
module tb_clk_wiz_sequencer;

  localparam int S_MMCM  = 0;
  localparam int S_DRST  = 1;
  localparam int S_READY = 2;
  localparam int S_FAULT = 3;
  localparam int S_RETRY = 4;
  localparam int S_LOSS  = 5;
  localparam int S_STATE = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       restart = 1'b0;
  logic       clear_fault = 1'b0;
  logic       locked = 1'b0;
  logic       mmcm_rst;
  logic       domain_rst_n;
  logic       ready;
  logic       fault;
  logic [1:0] retry_count;
  logic [7:0] lock_loss_count;
  logic [2:0] state_o;

  typedef struct {
    int    cyc;
    int    sig;
    int    val;
    string name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  event chk_ev;

  clk_wiz_sequencer #(
    .RST_PULSE_CYCLES    (4),
    .LOCK_TIMEOUT_CYCLES (32),
    .LOCK_STABLE_CYCLES  (8),
    .MAX_RETRIES         (2)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .enable          (enable),
    .restart         (restart),
    .clear_fault     (clear_fault),
    .locked          (locked),
    .mmcm_rst        (mmcm_rst),
    .domain_rst_n    (domain_rst_n),
    .ready           (ready),
    .fault           (fault),
    .retry_count     (retry_count),
    .lock_loss_count (lock_loss_count),
    .state_o         (state_o)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Rising-edge counter used to time expectations.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int read_sig(input int sig);
    case (sig)
      S_MMCM:  return int'(mmcm_rst);
      S_DRST:  return int'(domain_rst_n);
      S_READY: return int'(ready);
      S_FAULT: return int'(fault);
      S_RETRY: return int'(retry_count);
      S_LOSS:  return int'(lock_loss_count);
      default: return int'(state_o);
    endcase
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Expect a value after the dly-th upcoming rising edge.
  task automatic check_output(input int dly, input int sig, input int val, input string name);
    sb.push_back('{cyc + dly, sig, val, name});
  endtask

  // Expect a value right now, without waiting for a clock edge.
  task automatic check_now(input int sig, input int val, input string name);
    sb.push_back('{-1, sig, val, name});
  endtask

  task automatic apply_stimulus(input int dummy);
    -> chk_ev;
    #1;
  endtask

  // Monitor: compare every due expectation and retire it.
  initial begin
    forever begin
      @(negedge clk or chk_ev);
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].cyc == cyc || sb[i].cyc < 0) begin
          int act;
          act = read_sig(sb[i].sig);
          checks++;
          if (act != sb[i].val) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)",
                     sb[i].name, act, sb[i].val, cyc);
          end
          sb.delete(i);
        end else if (sb[i].cyc < cyc) begin
          checks++;
          failures++;
          $display("[TB] FAIL %s: expectation for cycle %0d was never sampled", sb[i].name, sb[i].cyc);
          sb.delete(i);
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    enable = 1'b1;
    step(2);
    #1;
    check_now(S_MMCM, 1, "rst_mmcm");
    check_now(S_DRST, 0, "rst_domain");
    check_now(S_READY, 0, "rst_ready");
    check_now(S_FAULT, 0, "rst_fault");
    check_now(S_RETRY, 0, "rst_retry");
    check_now(S_LOSS, 0, "rst_loss");
    check_now(S_STATE, 0, "rst_state");
    apply_stimulus(0);
    step(1);

    // Bring-up.
    rst_n = 1'b1;
    check_output(1, S_STATE, 1, "bring_pulse");
    check_output(4, S_MMCM, 1, "bring_mmcm_hi");
    check_output(4, S_STATE, 1, "bring_pulse_end");
    check_output(5, S_MMCM, 0, "bring_mmcm_lo");
    check_output(5, S_STATE, 2, "bring_wait");
    step(15);
    locked = 1'b1;
    check_output(3, S_STATE, 3, "bring_stab");
    check_output(10, S_READY, 0, "bring_ready_early");
    check_output(10, S_DRST, 0, "bring_drst_early");
    check_output(11, S_READY, 1, "bring_ready");
    check_output(11, S_DRST, 1, "bring_drst");
    check_output(11, S_RETRY, 0, "bring_retry");
    check_output(11, S_STATE, 4, "bring_running");
    step(14);

    // Lock loss in RUNNING.
    locked = 1'b0;
    check_output(2, S_READY, 1, "loss_ready_hold");
    check_output(3, S_READY, 0, "loss_ready");
    check_output(3, S_DRST, 0, "loss_drst");
    check_output(3, S_LOSS, 1, "loss_count");
    check_output(3, S_MMCM, 1, "loss_mmcm");
    check_output(3, S_STATE, 1, "loss_state");
    check_output(6, S_MMCM, 1, "loss_mmcm_hold");
    check_output(7, S_MMCM, 0, "loss_mmcm_lo");
    step(8);
    locked = 1'b1;
    check_output(11, S_READY, 1, "loss_relock");
    step(12);

    // Restart in RUNNING.
    restart = 1'b1;
    check_output(1, S_STATE, 1, "rs_state");
    check_output(1, S_MMCM, 1, "rs_mmcm");
    check_output(1, S_READY, 0, "rs_ready");
    check_output(1, S_LOSS, 1, "rs_loss");
    check_output(4, S_MMCM, 1, "rs_mmcm_hold");
    check_output(5, S_MMCM, 0, "rs_mmcm_lo");
    check_output(13, S_READY, 0, "rs_ready_early");
    check_output(14, S_READY, 1, "rs_ready_back");
    step(1);
    restart = 1'b0;
    step(14);

    // Restart on the same edge the lock loss is seen.
    locked = 1'b0;
    check_output(3, S_STATE, 1, "rsloss_state");
    check_output(3, S_LOSS, 1, "rsloss_loss");
    check_output(3, S_READY, 0, "rsloss_ready");
    step(2);
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    step(5);
    locked = 1'b1;
    check_output(11, S_READY, 1, "rsloss_relock");
    step(12);

    // Repeated losses until the counter saturates.
    for (int i = 2; i <= 260; i++) begin
      locked = 1'b0;
      check_output(3, S_LOSS, (i > 255) ? 255 : i, "loss_sat");
      step(8);
      locked = 1'b1;
      step(12);
    end

    // Single-cycle glitch during STABILIZE.
    locked = 1'b0;
    check_output(3, S_LOSS, 255, "loss_hold_255");
    step(8);
    locked = 1'b1;
    check_output(3, S_STATE, 3, "glitch_stab");
    step(7);
    locked = 1'b0;
    step(1);
    locked = 1'b1;
    check_output(2, S_STATE, 2, "glitch_wait");
    check_output(2, S_MMCM, 0, "glitch_no_pulse");
    check_output(2, S_READY, 0, "glitch_ready");
    check_output(2, S_RETRY, 0, "glitch_retry");
    check_output(3, S_STATE, 3, "glitch_restab");
    check_output(10, S_READY, 0, "glitch_ready_early");
    check_output(11, S_READY, 1, "glitch_ready_back");
    step(12);

    // Restart together with enable low.
    restart = 1'b1;
    enable  = 1'b0;
    check_output(1, S_STATE, 0, "rsen_state");
    check_output(1, S_MMCM, 1, "rsen_mmcm");
    check_output(1, S_READY, 0, "rsen_ready");
    check_output(1, S_DRST, 0, "rsen_drst");
    step(1);
    restart = 1'b0;
    locked  = 1'b0;
    step(3);

    // Timeout on every attempt ends in FAULT.
    enable = 1'b1;
    check_output(1, S_STATE, 1, "to_pulse1");
    check_output(1, S_RETRY, 0, "to_retry0");
    check_output(5, S_MMCM, 0, "to_mmcm_lo1");
    check_output(36, S_STATE, 2, "to_wait_end1");
    check_output(37, S_STATE, 1, "to_pulse2");
    check_output(37, S_RETRY, 1, "to_retry1");
    check_output(37, S_MMCM, 1, "to_mmcm_hi2");
    check_output(41, S_MMCM, 0, "to_mmcm_lo2");
    check_output(73, S_RETRY, 2, "to_retry2");
    check_output(73, S_MMCM, 1, "to_mmcm_hi3");
    check_output(108, S_FAULT, 0, "to_fault_early");
    check_output(109, S_FAULT, 1, "to_fault");
    check_output(109, S_MMCM, 1, "to_fault_mmcm");
    check_output(109, S_STATE, 5, "to_fault_state");
    check_output(109, S_RETRY, 2, "to_fault_retry");
    step(111);

    // Restart is ignored in FAULT; clear_fault leaves it.
    restart = 1'b1;
    check_output(1, S_STATE, 5, "fault_rs_state");
    check_output(1, S_FAULT, 1, "fault_rs_fault");
    step(1);
    restart = 1'b0;
    step(2);
    clear_fault = 1'b1;
    check_output(1, S_STATE, 1, "clr_state");
    check_output(1, S_FAULT, 0, "clr_fault");
    check_output(1, S_RETRY, 0, "clr_retry");
    check_output(1, S_MMCM, 1, "clr_mmcm");
    step(1);
    clear_fault = 1'b0;
    step(4);

    // Asynchronous reset mid-STABILIZE.
    locked = 1'b1;
    check_output(3, S_STATE, 3, "ar_stab");
    step(5);
    for (int k = 0; k < 50 && sb.size() > 0; k++) step(1);
    #2;
    rst_n = 1'b0;
    #1;
    check_now(S_MMCM, 1, "ar_mmcm");
    check_now(S_READY, 0, "ar_ready");
    check_now(S_STATE, 0, "ar_state");
    check_now(S_DRST, 0, "ar_drst");
    check_now(S_LOSS, 0, "ar_loss");
    check_now(S_RETRY, 0, "ar_retry");
    apply_stimulus(0);
    step(2);
    for (int k = 0; k < 50 && sb.size() > 0; k++) step(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
